// File: rtl/demux32bit1to2_reg_pkg.sv
// Shared constants and types for the registered 1-to-2 word steering unit.
// Select encoding matches the 2:1 word mux so producers can share decode logic.
package demux32bit1to2_reg_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with valid/ready handshake and a delivered-word counter.
// A load may coincide with a drain, giving full-rate pass-through.
module demux_slot
    import demux32bit1to2_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              can_accept,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  count
);

    slot_state_t       state_q;
    slot_state_t       state_d;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  count_q;
    logic              drain;

    assign drain      = (state_q == SLOT_FULL) && out_ready;
    assign can_accept = (state_q == SLOT_EMPTY) || out_ready;
    assign out_valid  = (state_q == SLOT_FULL);
    assign out_data   = data_q;
    assign count      = count_q;

    // A refill takes priority over a drain so the slot stays full when both happen.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SLOT_FULL;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data holds its last value when empty; consumers qualify with valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (cnt_clr) begin
            count_q <= '0;
        end else if (drain) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux32bit1to2_reg.sv
// Registered 1-to-2 word steering unit: routes each accepted input word to channel A or B.
// Input is strictly in-order; a blocked head word stalls the input even if the other channel is free.
module demux32bit1to2_reg
    import demux32bit1to2_reg_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [DATA_W-1:0] b_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  a_count,
    output logic [CNT_W-1:0]  b_count
);

    logic a_can_accept;
    logic b_can_accept;
    logic accept;
    logic load_a;
    logic load_b;

    assign in_ready = reset_n && ((in_sel == SEL_B) ? b_can_accept : a_can_accept);
    assign accept   = in_valid && in_ready;
    assign load_a   = accept && (in_sel == SEL_A);
    assign load_b   = accept && (in_sel == SEL_B);

    demux_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_a),
        .load_data  (in_data),
        .can_accept (a_can_accept),
        .out_valid  (a_valid),
        .out_ready  (a_ready),
        .out_data   (a_data),
        .cnt_clr    (cnt_clr),
        .count      (a_count)
    );

    demux_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_b),
        .load_data  (in_data),
        .can_accept (b_can_accept),
        .out_valid  (b_valid),
        .out_ready  (b_ready),
        .out_data   (b_data),
        .cnt_clr    (cnt_clr),
        .count      (b_count)
    );

endmodule

// File: tb/tb_demux32bit1to2_reg.sv
// Self-checking bench for demux32bit1to2_reg with a queue-based reference model.
// Counters are narrowed to 4 bits so wrap-around is reachable quickly.
module tb_demux32bit1to2_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_sel;
    logic [DATA_W-1:0] in_data;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [DATA_W-1:0] b_data;
    logic              cnt_clr;
    logic [CNT_W-1:0]  a_count;
    logic [CNT_W-1:0]  b_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: words waiting per channel, last loaded word, delivered counts.
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    logic [DATA_W-1:0] m_a_last = '0;
    logic [DATA_W-1:0] m_b_last = '0;
    logic [CNT_W-1:0]  m_a_cnt  = '0;
    logic [CNT_W-1:0]  m_b_cnt  = '0;

    always #5 clk = ~clk;

    demux32bit1to2_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .cnt_clr  (cnt_clr),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    function automatic bit exp_ready();
        if (!reset_n) return 1'b0;
        if (in_sel) return (qb.size() == 0) || b_ready;
        return (qa.size() == 0) || a_ready;
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        bit fa;
        bit fb;
        bit acc;
        bit s;
        bit clr;
        bit rn;
        logic [DATA_W-1:0] d;
        fa  = (qa.size() != 0) && a_ready;
        fb  = (qb.size() != 0) && b_ready;
        acc = in_valid && exp_ready();
        s   = in_sel;
        d   = in_data;
        clr = cnt_clr;
        rn  = reset_n;
        @(posedge clk);
        if (!rn) begin
            qa.delete();
            qb.delete();
            m_a_last = '0;
            m_b_last = '0;
            m_a_cnt  = '0;
            m_b_cnt  = '0;
        end else begin
            if (fa) void'(qa.pop_front());
            if (fb) void'(qb.pop_front());
            m_a_cnt = clr ? '0 : m_a_cnt + (fa ? CNT_W'(1) : CNT_W'(0));
            m_b_cnt = clr ? '0 : m_b_cnt + (fb ? CNT_W'(1) : CNT_W'(0));
            if (acc) begin
                if (s) begin
                    qb.push_back(d);
                    m_b_last = d;
                end else begin
                    qa.push_back(d);
                    m_a_last = d;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hCAFE0000;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        cnt_clr  = 1'b0;
        @(negedge clk);
        tick();
        tick();
        #1;
        n_cmp += 5;
        if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        if (a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_a_valid got %b want 0", a_valid); end
        if (b_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_b_valid got %b want 0", b_valid); end
        if (a_count !== '0) begin n_fail++; $display("[TB] FAIL reset_a_count got %0d want 0", a_count); end
        if (b_count !== '0) begin n_fail++; $display("[TB] FAIL reset_b_count got %0d want 0", b_count); end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        n_cmp += 3;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready got %b want 1", in_ready); end
        if (a_data !== '0) begin n_fail++; $display("[TB] FAIL reset_a_data got %h want 0", a_data); end
        if (b_data !== '0) begin n_fail++; $display("[TB] FAIL reset_b_data got %h want 0", b_data); end
    endtask

    task automatic test_basic_routing();
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL route_ready got %b want 1", in_ready); end
        tick();
        in_sel  = 1'b1;
        in_data = 32'h12345678;
        #1;
        n_cmp += 2;
        if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL route_a_valid got %b want 1", a_valid); end
        if (a_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL route_a_data got %h want deadbeef", a_data); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp += 3;
        if (b_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL route_b_valid got %b want 1", b_valid); end
        if (b_data !== 32'h12345678) begin n_fail++; $display("[TB] FAIL route_b_data got %h want 12345678", b_data); end
        if (a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL route_a_drained got %b want 0", a_valid); end
        tick();
        n_cmp += 2;
        if (a_count !== CNT_W'(1)) begin n_fail++; $display("[TB] FAIL route_a_count got %0d want 1", a_count); end
        if (b_count !== CNT_W'(1)) begin n_fail++; $display("[TB] FAIL route_b_count got %0d want 1", b_count); end
    endtask

    task automatic test_back_pressure();
        a_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h1;
        tick();
        in_data = 32'h2;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp += 3;
            if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready got %b want 0", in_ready); end
            if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_a_valid got %b want 1", a_valid); end
            if (a_data !== 32'h1) begin n_fail++; $display("[TB] FAIL bp_a_data got %h want 1", a_data); end
            tick();
        end
        a_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp += 2;
        if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_no_bubble got %b want 1", a_valid); end
        if (a_data !== 32'h2) begin n_fail++; $display("[TB] FAIL bp_second_data got %h want 2", a_data); end
        tick();
    endtask

    task automatic test_independent_drain();
        a_ready  = 1'b0;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hAAAA0001;
        tick();
        in_sel  = 1'b1;
        in_data = 32'hBBBB0002;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL indep_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp += 4;
        if (b_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL indep_b_valid got %b want 1", b_valid); end
        if (b_data !== 32'hBBBB0002) begin n_fail++; $display("[TB] FAIL indep_b_data got %h want bbbb0002", b_data); end
        if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL indep_a_valid got %b want 1", a_valid); end
        if (a_data !== 32'hAAAA0001) begin n_fail++; $display("[TB] FAIL indep_a_data got %h want aaaa0001", a_data); end
        a_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_streaming();
        logic [CNT_W-1:0] want;
        a_ready = 1'b1;
        b_ready = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_sel  = i[0];
            in_data = $urandom;
            #1;
            n_cmp += 3;
            if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
            if (a_valid !== (qa.size() != 0) || a_data !== m_a_last) begin
                n_fail++; $display("[TB] FAIL stream_a[%0d] got v=%b d=%h want v=%b d=%h", i, a_valid, a_data, qa.size() != 0, m_a_last);
            end
            if (b_valid !== (qb.size() != 0) || b_data !== m_b_last) begin
                n_fail++; $display("[TB] FAIL stream_b[%0d] got v=%b d=%h want v=%b d=%h", i, b_valid, b_data, qb.size() != 0, m_b_last);
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        want = CNT_W'(50 % (1 << CNT_W));
        n_cmp += 2;
        if (a_count !== want) begin n_fail++; $display("[TB] FAIL stream_a_count got %0d want %0d", a_count, want); end
        if (b_count !== want) begin n_fail++; $display("[TB] FAIL stream_b_count got %0d want %0d", b_count, want); end
    endtask

    task automatic test_counter_edges();
        a_ready = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (a_count !== CNT_W'(1)) begin n_fail++; $display("[TB] FAIL cnt_wrap got %0d want 1", a_count); end
        in_valid = 1'b1;
        in_data  = 32'h5A5A5A5A;
        tick();
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        #1;
        n_cmp++;
        if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_setup_valid got %b want 1", a_valid); end
        tick();
        cnt_clr = 1'b0;
        n_cmp++;
        if (a_count !== '0) begin n_fail++; $display("[TB] FAIL clr_wins got %0d want 0", a_count); end
    endtask

    task automatic test_reset_mid();
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h0000AAAA;
        tick();
        in_sel  = 1'b1;
        in_data = 32'h0000BBBB;
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_valid !== 1'b1 || b_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_setup got a=%b b=%b want 1 1", a_valid, b_valid); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp += 3;
            if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid[%0d] got a=%b b=%b want 0 0", i, a_valid, b_valid); end
            if (a_data !== '0 || b_data !== '0) begin n_fail++; $display("[TB] FAIL mid_data[%0d] got a=%h b=%h want 0 0", i, a_data, b_data); end
            if (a_count !== '0 || b_count !== '0) begin n_fail++; $display("[TB] FAIL mid_count[%0d] got a=%0d b=%0d want 0 0", i, a_count, b_count); end
            tick();
        end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_sel   = $urandom_range(0, 1);
            in_data  = $urandom;
            a_ready  = $urandom_range(0, 2) != 0;
            b_ready  = $urandom_range(0, 2) != 0;
            cnt_clr  = $urandom_range(0, 31) == 0;
            #1;
            n_cmp += 5;
            if (in_ready !== exp_ready()) begin n_fail++; $display("[TB] FAIL rand_ready[%0d] got %b want %b", i, in_ready, exp_ready()); end
            if (a_valid !== (qa.size() != 0) || a_data !== m_a_last) begin
                n_fail++; $display("[TB] FAIL rand_a[%0d] got v=%b d=%h want v=%b d=%h", i, a_valid, a_data, qa.size() != 0, m_a_last);
            end
            if (b_valid !== (qb.size() != 0) || b_data !== m_b_last) begin
                n_fail++; $display("[TB] FAIL rand_b[%0d] got v=%b d=%h want v=%b d=%h", i, b_valid, b_data, qb.size() != 0, m_b_last);
            end
            if (a_count !== m_a_cnt) begin n_fail++; $display("[TB] FAIL rand_a_count[%0d] got %0d want %0d", i, a_count, m_a_cnt); end
            if (b_count !== m_b_cnt) begin n_fail++; $display("[TB] FAIL rand_b_count[%0d] got %0d want %0d", i, b_count, m_b_cnt); end
            tick();
        end
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_routing();
        test_back_pressure();
        test_independent_drain();
        test_streaming();
        test_counter_edges();
        test_reset_mid();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
